btn_event_arbiter: RTL

- Sits between the per-button debouncers and the game control FSM.
- Generates the shared sample tick that paces every debouncer.
- Turns debounced button levels into discrete press and auto-repeat events.
- Arbitrates simultaneous events by fixed priority, queues them in a small FIFO, and delivers them one at a time over a valid/ready handshake.

---
 rtl/btn_event_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/btn_event_arbiter.sv
// Button event arbiter: sample-tick divider, press/auto-repeat event
// generation, fixed-priority arbitration and a small valid/ready event FIFO.
module btn_event_arbiter #(
    parameter int                 NUM_BTN      = 5,
    parameter int                 DIV_BITS     = 18,
    parameter int                 FIFO_DEPTH   = 4,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK  = 5'b00110,
    parameter int                 REPEAT_DELAY = 16,
    parameter int                 REPEAT_RATE  = 4
) (
    input  logic                       clk_sys,
    input  logic                       rst_n,
    input  logic [NUM_BTN-1:0]         btn_level,
    output logic                       sample_tick,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(NUM_BTN)-1:0] evt_id,
    output logic                       evt_repeat,
    output logic                       overflow,
    input  logic                       clr_overflow
);

    localparam int ID_W     = $clog2(NUM_BTN);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RPT} rstate_t;

    logic [DIV_BITS-1:0] div_cnt;
    logic [NUM_BTN-1:0]  btn_prev;
    logic                init;
    logic [NUM_BTN-1:0]  press;
    logic [NUM_BTN-1:0]  pend;
    logic [NUM_BTN-1:0]  pend_sel;
    logic                rep_pend;
    logic [ID_W-1:0]     rep_id;
    logic                have_cand;
    logic                push;
    logic                push_rep;
    logic [ID_W-1:0]     push_id;
    logic                pop;
    logic                full;
    logic                ovf_set;

    rstate_t             state;
    logic [ID_W-1:0]     trk_id;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_nxt;
    logic                trk_any;
    logic [ID_W-1:0]     trk_idx;
    logic                abort;
    logic                fire;

    logic [ID_W:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [ID_W:0]       head;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            sample_tick <= 1'b0;
        end else begin
            div_cnt     <= div_cnt + DIV_BITS'(1);
            sample_tick <= &div_cnt;
        end
    end

    // init masks the first cycle so a button held through reset is not a press
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev <= '0;
            init     <= 1'b0;
        end else begin
            btn_prev <= btn_level;
            init     <= 1'b1;
        end
    end

    assign press = btn_level & ~btn_prev & {NUM_BTN{init}};

    always_comb begin
        pend_sel  = '0;
        push_id   = rep_id;
        push_rep  = 1'b1;
        have_cand = rep_pend;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pend[i]) begin
                pend_sel  = '0;
                pend_sel[i] = 1'b1;
                push_id   = ID_W'(i);
                push_rep  = 1'b0;
                have_cand = 1'b1;
            end
        end
    end

    assign pop  = evt_valid & evt_ready;
    assign full = (count == CNT_W'(FIFO_DEPTH));
    assign push = have_cand & (~full | pop);

    always_comb begin
        trk_any = 1'b0;
        trk_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (btn_level[i] & REPEAT_MASK[i]) begin
                trk_any = 1'b1;
                trk_idx = ID_W'(i);
            end
        end
    end

    assign hold_nxt = hold_cnt + HOLD_W'(1);
    assign abort = (state != R_IDLE) &&
                   (!btn_level[trk_id] || (trk_any && (trk_idx < trk_id)));
    assign fire = !abort && sample_tick &&
                  (((state == R_DELAY) && (hold_nxt == HOLD_W'(REPEAT_DELAY))) ||
                   ((state == R_RPT)   && (hold_nxt == HOLD_W'(REPEAT_RATE))));

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state    <= R_IDLE;
            trk_id   <= '0;
            hold_cnt <= '0;
        end else begin
            unique case (state)
                R_IDLE: begin
                    if (trk_any) begin
                        trk_id   <= trk_idx;
                        hold_cnt <= '0;
                        state    <= R_DELAY;
                    end
                end
                R_DELAY, R_RPT: begin
                    if (abort) begin
                        hold_cnt <= '0;
                        state    <= R_IDLE;
                    end else if (fire) begin
                        hold_cnt <= '0;
                        state    <= R_RPT;
                    end else if (sample_tick) begin
                        hold_cnt <= hold_nxt;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

    // a press or repeat landing on an already-pending request merges and is flagged
    assign ovf_set = (|(press & pend)) | (fire & rep_pend);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            rep_pend <= 1'b0;
            rep_id   <= '0;
            overflow <= 1'b0;
        end else begin
            pend     <= (pend & ~(push ? pend_sel : '0)) | press;
            rep_pend <= (rep_pend & ~(push & push_rep)) | fire;
            if (fire) rep_id <= trk_id;
            if (ovf_set) overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {push_rep, push_id};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign head       = mem[rd_ptr];
    assign evt_valid  = (count != '0);
    assign evt_id     = evt_valid ? head[ID_W-1:0] : '0;
    assign evt_repeat = evt_valid & head[ID_W];

endmodule
